// File: rtl/matrix_pkg.sv
// Shared types and constants for the 4x4 matrix ALU: bus offsets, opcodes,
// FSM states and a helper to pick one element out of a packed matrix.
package matrix_pkg;

  localparam int MAT_W  = 256;
  localparam int ELEM_W = 16;
  localparam int ROW_W  = 4 * ELEM_W;

  localparam logic [3:0] OFF_SRCA   = 4'd0;
  localparam logic [3:0] OFF_SRCB   = 4'd1;
  localparam logic [3:0] OFF_CTRL   = 4'd2;
  localparam logic [3:0] OFF_RESULT = 4'd3;
  localparam logic [3:0] OFF_STATUS = 4'd4;

  localparam int CTRL_START_BIT = 8;

  typedef enum logic [2:0] {
    OP_ADD       = 3'd0,
    OP_SUB       = 3'd1,
    OP_EMUL      = 3'd2,
    OP_SCALE     = 3'd3,
    OP_TRANSPOSE = 3'd4,
    OP_RSV5      = 3'd5,
    OP_RSV6      = 3'd6,
    OP_RSV7      = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic isLegalOp(input logic [2:0] op);
    return op <= OP_TRANSPOSE;
  endfunction

  // Element [r][c] lives at bits (r*4+c)*16 +: 16.
  function automatic logic [ELEM_W-1:0] elemOf(input logic [MAT_W-1:0] m,
                                               input int r, input int c);
    return m[(r*4+c)*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/matrix_alu_if.sv
// Bus between the execution engine (master) and the matrix ALU (slave).
interface matrix_alu_if;
  import matrix_pkg::*;

  logic [MAT_W-1:0] DataIn;
  logic [MAT_W-1:0] DataOut;
  logic [15:0]      address;
  logic             nRead;
  logic             nWrite;
  logic             Busy;

  modport master (
    output DataIn, address, nRead, nWrite,
    input  DataOut, Busy
  );

  modport slave (
    input  DataIn, address, nRead, nWrite,
    output DataOut, Busy
  );

endinterface

// File: rtl/matrix_row_alu.sv
// Combinational datapath producing one 64-bit result row; all arithmetic
// wraps modulo 2^16 because every result is kept in a 16-bit element.
module matrix_row_alu
  import matrix_pkg::*;
(
  input  opcode_e           opcode,
  input  logic [1:0]        rowIdx,
  input  logic [MAT_W-1:0]  srcA,
  input  logic [MAT_W-1:0]  srcB,
  input  logic [ELEM_W-1:0] bScalar,
  output logic [ROW_W-1:0]  rowOut
);

  always_comb begin
    rowOut = '0;
    for (int c = 0; c < 4; c++) begin
      case (opcode)
        OP_ADD:
          rowOut[c*ELEM_W +: ELEM_W] = elemOf(srcA, int'(rowIdx), c) + elemOf(srcB, int'(rowIdx), c);
        OP_SUB:
          rowOut[c*ELEM_W +: ELEM_W] = elemOf(srcA, int'(rowIdx), c) - elemOf(srcB, int'(rowIdx), c);
        OP_EMUL:
          rowOut[c*ELEM_W +: ELEM_W] = elemOf(srcA, int'(rowIdx), c) * elemOf(srcB, int'(rowIdx), c);
        OP_SCALE:
          rowOut[c*ELEM_W +: ELEM_W] = elemOf(srcA, int'(rowIdx), c) * bScalar;
        OP_TRANSPOSE:
          rowOut[c*ELEM_W +: ELEM_W] = elemOf(srcA, c, int'(rowIdx));
        default:
          rowOut[c*ELEM_W +: ELEM_W] = '0;
      endcase
    end
  end

endmodule

// File: rtl/matrix_alu.sv
// Memory-mapped 4x4 matrix ALU: register file, bus decode, status tracking
// and a row-per-cycle IDLE/COMPUTE/DONE sequencer.
module matrix_alu
  import matrix_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h3000
) (
  input logic         Clk,
  input logic         Reset,
  matrix_alu_if.slave bus
);

  logic [MAT_W-1:0] srcA, srcB, result, workBuf, dataOut, readData;
  logic [2:0]       ctrlOp;
  logic             statusDone, statusError;
  state_e           state;
  logic [1:0]       rowIdx;
  logic [ROW_W-1:0] rowResult;

  logic [3:0] offset;
  logic hit, wrHit, rdHit, rdEn, bothLow, busy, regOff;
  logic wrAccept, ctrlStart, startOk, errSet, doneSet, statusClear;

  assign offset = bus.address[3:0];
  assign hit    = (bus.address[15:4] == BASE_ADDR[15:4]);
  assign wrHit  = hit & ~bus.nWrite;
  assign rdHit  = hit & ~bus.nRead;
  assign rdEn   = rdHit & bus.nWrite;
  assign bothLow = rdHit & ~bus.nWrite;
  assign busy   = (state != ST_IDLE);
  assign regOff = (offset == OFF_SRCA) || (offset == OFF_SRCB) || (offset == OFF_CTRL);

  // A write lands only when idle and aimed at a writable register.
  assign wrAccept  = wrHit & ~busy & regOff;
  assign ctrlStart = wrAccept & (offset == OFF_CTRL) & bus.DataIn[CTRL_START_BIT];
  assign startOk   = ctrlStart & isLegalOp(bus.DataIn[2:0]);

  assign errSet = (wrHit & busy)
                | (wrHit & ~regOff)
                | (ctrlStart & ~isLegalOp(bus.DataIn[2:0]))
                | bothLow;
  assign doneSet     = (state == ST_DONE);
  assign statusClear = rdEn & (offset == OFF_STATUS);

  always_comb begin
    readData = '0;
    case (offset)
      OFF_SRCA:   readData = srcA;
      OFF_SRCB:   readData = srcB;
      OFF_CTRL:   readData[2:0] = ctrlOp;
      OFF_RESULT: readData = result;
      OFF_STATUS: readData[2:0] = {statusError, statusDone, busy};
      default:    readData = '0;
    endcase
  end

  matrix_row_alu rowAlu (
    .opcode  (opcode_e'(ctrlOp)),
    .rowIdx  (rowIdx),
    .srcA    (srcA),
    .srcB    (srcB),
    .bScalar (srcB[ELEM_W-1:0]),
    .rowOut  (rowResult)
  );

  // Status sets take priority over the read-to-clear of the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      srcA        <= '0;
      srcB        <= '0;
      ctrlOp      <= '0;
      result      <= '0;
      workBuf     <= '0;
      dataOut     <= '0;
      statusDone  <= 1'b0;
      statusError <= 1'b0;
      rowIdx      <= '0;
      state       <= ST_IDLE;
    end else begin
      dataOut     <= rdEn ? readData : '0;
      statusDone  <= doneSet | (statusDone & ~statusClear);
      statusError <= errSet | (statusError & ~statusClear);

      if (wrAccept) begin
        case (offset)
          OFF_SRCA: srcA   <= bus.DataIn;
          OFF_SRCB: srcB   <= bus.DataIn;
          OFF_CTRL: ctrlOp <= bus.DataIn[2:0];
          default:  ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (startOk) begin
            rowIdx <= '0;
            state  <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          workBuf[{rowIdx, 6'b0} +: ROW_W] <= rowResult;
          rowIdx <= rowIdx + 2'd1;
          if (rowIdx == 2'd3) state <= ST_DONE;
        end
        ST_DONE: begin
          result <= workBuf;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.DataOut = dataOut;
  assign bus.Busy    = busy;

endmodule

// File: tb/tb_matrix_alu.sv
// Directed bench for matrix_alu: bus transactions at the falling edge,
// outputs checked one falling edge after the edge that acted on them.
module tb_matrix_alu;
  import matrix_pkg::*;

  localparam logic [15:0] BASE = 16'h3000;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount = 0;

  matrix_alu_if bus();

  matrix_alu #(.BASE_ADDR(BASE)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MAT_W-1:0] fillAll(input logic [15:0] v);
    logic [MAT_W-1:0] m;
    for (int i = 0; i < 16; i++) m[i*16 +: 16] = v;
    return m;
  endfunction

  // Element [r][c] = mul * (r*4+c), or mul * (c*4+r) when transposed.
  function automatic logic [MAT_W-1:0] idxMat(input int mul, input bit transposed);
    logic [MAT_W-1:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m[(r*4+c)*16 +: 16] = 16'(mul * (transposed ? (c*4+r) : (r*4+c)));
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] ctrlWord(input logic [2:0] op, input logic start);
    logic [MAT_W-1:0] w;
    w = '0;
    w[2:0] = op;
    w[8] = start;
    return w;
  endfunction

  function automatic logic [MAT_W-1:0] statusWord(input logic [2:0] s);
    return MAT_W'(s);
  endfunction

  task automatic applyStimulus(input logic [15:0] addr, input logic [MAT_W-1:0] data,
                               input logic rdN, input logic wrN);
    bus.address = addr;
    bus.DataIn  = data;
    bus.nRead   = rdN;
    bus.nWrite  = wrN;
    @(posedge clk);
    #1;
    bus.nRead  = 1'b1;
    bus.nWrite = 1'b1;
    @(negedge clk);
  endtask

  task automatic writeReg(input logic [3:0] off, input logic [MAT_W-1:0] data);
    applyStimulus(BASE | {12'h000, off}, data, 1'b1, 1'b0);
  endtask

  task automatic readReg(input logic [3:0] off);
    applyStimulus(BASE | {12'h000, off}, '0, 1'b0, 1'b1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [MAT_W-1:0] observed,
                             input logic [MAT_W-1:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
    end
  endtask

  logic [MAT_W-1:0] scaleB;
  logic [MAT_W-1:0] addExp;

  initial begin
    reset       = 1'b1;
    bus.address = '0;
    bus.DataIn  = '0;
    bus.nRead   = 1'b1;
    bus.nWrite  = 1'b1;

    scaleB = fillAll(16'hAAAA);
    scaleB[15:0] = 16'h0003;
    addExp = idxMat(1, 1'b0);
    for (int k = 0; k < 16; k++) addExp[k*16 +: 16] = addExp[k*16 +: 16] + scaleB[k*16 +: 16];

    @(negedge clk);
    @(negedge clk);
    checkOutput("resetBusy", MAT_W'(bus.Busy), '0);
    checkOutput("resetDataOut", bus.DataOut, '0);
    reset = 1'b0;

    // First transaction right after reset release must be honoured
    writeReg(OFF_SRCA, fillAll(16'h0003));
    readReg(OFF_SRCA);
    checkOutput("firstWriteSrcA", bus.DataOut, fillAll(16'h0003));
    readReg(OFF_RESULT);
    checkOutput("resetResult", bus.DataOut, '0);
    readReg(OFF_STATUS);
    checkOutput("resetStatus", bus.DataOut, '0);

    // ADD with exact busy window
    writeReg(OFF_SRCB, fillAll(16'h0002));
    writeReg(OFF_CTRL, ctrlWord(3'd0, 1'b1));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("addBusyCycle%0d", i), MAT_W'(bus.Busy), MAT_W'(1));
      idleCycles(1);
    end
    checkOutput("addBusyLow", MAT_W'(bus.Busy), '0);
    readReg(OFF_RESULT);
    checkOutput("addResult", bus.DataOut, fillAll(16'h0005));
    readReg(OFF_STATUS);
    checkOutput("addStatusDone", bus.DataOut, statusWord(3'b010));
    readReg(OFF_STATUS);
    checkOutput("addStatusCleared", bus.DataOut, '0);
    readReg(OFF_CTRL);
    checkOutput("addCtrlRead", bus.DataOut, '0);

    // SUB wrap; Result must keep the old value while computing
    writeReg(OFF_SRCA, fillAll(16'h0001));
    writeReg(OFF_SRCB, fillAll(16'h0002));
    writeReg(OFF_CTRL, ctrlWord(3'd1, 1'b1));
    readReg(OFF_RESULT);
    checkOutput("subResultHeld", bus.DataOut, fillAll(16'h0005));
    readReg(OFF_STATUS);
    checkOutput("subStatusBusy", bus.DataOut, statusWord(3'b001));
    idleCycles(3);
    checkOutput("subBusyLow", MAT_W'(bus.Busy), '0);
    readReg(OFF_RESULT);
    checkOutput("subResult", bus.DataOut, fillAll(16'hFFFF));

    // EMUL wrap
    writeReg(OFF_SRCA, fillAll(16'h0100));
    writeReg(OFF_SRCB, fillAll(16'h0100));
    writeReg(OFF_CTRL, ctrlWord(3'd2, 1'b1));
    idleCycles(5);
    readReg(OFF_RESULT);
    checkOutput("emulResult", bus.DataOut, '0);
    readReg(OFF_STATUS);
    checkOutput("emulStatus", bus.DataOut, statusWord(3'b010));

    // TRANSPOSE and SCALE on an indexed matrix
    writeReg(OFF_SRCA, idxMat(1, 1'b0));
    writeReg(OFF_CTRL, ctrlWord(3'd4, 1'b1));
    idleCycles(5);
    readReg(OFF_RESULT);
    checkOutput("transposeResult", bus.DataOut, idxMat(1, 1'b1));
    writeReg(OFF_SRCB, scaleB);
    writeReg(OFF_CTRL, ctrlWord(3'd3, 1'b1));
    idleCycles(5);
    readReg(OFF_RESULT);
    checkOutput("scaleResult", bus.DataOut, idxMat(3, 1'b0));
    readReg(OFF_STATUS);
    checkOutput("scaleStatus", bus.DataOut, statusWord(3'b010));

    // Illegal opcode
    writeReg(OFF_CTRL, ctrlWord(3'd6, 1'b1));
    checkOutput("illegalOpBusy", MAT_W'(bus.Busy), '0);
    readReg(OFF_STATUS);
    checkOutput("illegalOpStatus", bus.DataOut, statusWord(3'b100));
    readReg(OFF_CTRL);
    checkOutput("illegalOpCtrl", bus.DataOut, MAT_W'(6));
    readReg(OFF_STATUS);
    checkOutput("illegalOpCleared", bus.DataOut, '0);

    // SrcA write while busy is dropped
    writeReg(OFF_CTRL, ctrlWord(3'd0, 1'b1));
    writeReg(OFF_SRCA, fillAll(16'hFFFF));
    idleCycles(4);
    checkOutput("busyWriteBusyLow", MAT_W'(bus.Busy), '0);
    readReg(OFF_STATUS);
    checkOutput("busyWriteStatus", bus.DataOut, statusWord(3'b110));
    readReg(OFF_SRCA);
    checkOutput("busyWriteSrcA", bus.DataOut, idxMat(1, 1'b0));
    readReg(OFF_RESULT);
    checkOutput("busyWriteResult", bus.DataOut, addExp);

    // Reset during the third compute cycle
    writeReg(OFF_SRCA, fillAll(16'h0003));
    writeReg(OFF_SRCB, fillAll(16'h0002));
    writeReg(OFF_CTRL, ctrlWord(3'd0, 1'b1));
    idleCycles(2);
    reset = 1'b1;
    #1;
    checkOutput("midResetBusy", MAT_W'(bus.Busy), '0);
    @(negedge clk);
    reset = 1'b0;
    readReg(OFF_RESULT);
    checkOutput("midResetResult", bus.DataOut, '0);
    readReg(OFF_STATUS);
    checkOutput("midResetStatus", bus.DataOut, '0);
    writeReg(OFF_SRCA, fillAll(16'h0003));
    writeReg(OFF_SRCB, fillAll(16'h0002));
    writeReg(OFF_CTRL, ctrlWord(3'd0, 1'b1));
    idleCycles(5);
    readReg(OFF_RESULT);
    checkOutput("postResetAdd", bus.DataOut, fillAll(16'h0005));
    readReg(OFF_STATUS);
    checkOutput("postResetStatus", bus.DataOut, statusWord(3'b010));

    // Address decode and reserved offsets
    readReg(OFF_RESULT);
    applyStimulus(16'h1000, '0, 1'b0, 1'b1);
    checkOutput("outOfWindowRead", bus.DataOut, '0);
    readReg(OFF_RESULT);
    readReg(4'd7);
    checkOutput("reservedRead", bus.DataOut, '0);

    // Write to Result is rejected
    writeReg(OFF_RESULT, fillAll(16'h1234));
    readReg(OFF_RESULT);
    checkOutput("resultWriteIgnored", bus.DataOut, fillAll(16'h0005));
    readReg(OFF_STATUS);
    checkOutput("resultWriteStatus", bus.DataOut, statusWord(3'b100));

    // Simultaneous read and write strobes on Ctrl
    readReg(OFF_RESULT);
    applyStimulus(BASE | {12'h000, OFF_CTRL}, ctrlWord(3'd3, 1'b0), 1'b0, 1'b0);
    checkOutput("bothLowDataOut", bus.DataOut, '0);
    readReg(OFF_CTRL);
    checkOutput("bothLowCtrl", bus.DataOut, MAT_W'(3));
    readReg(OFF_STATUS);
    checkOutput("bothLowStatus", bus.DataOut, statusWord(3'b100));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/matrix_alu.md
MATRIX_ALU -- requirements
Module: matrix_alu

Interface
REQ-001 Parameter BASE_ADDR, default 16'h3000; base of the block's 16-word address window on the shared bus.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 DataIn  input  256  write data from the execution engine's data-out bus.
REQ-005 DataOut  output  256  registered read data returned to the execution engine.
REQ-006 address  input  16  bus address, sampled on Clk rising edge.
REQ-007 nRead  input  1  active-low read strobe.
REQ-008 nWrite  input  1  active-low write strobe.
REQ-009 Busy  output  1  high while a matrix operation is in progress.

Function
REQ-010 Hit when address[15:4]==BASE_ADDR[15:4]; offset=address[3:0]: 0 SrcA, 1 SrcB, 2 Ctrl, 3 Result, 4 Status; offsets 5-15 reserved.
REQ-011 Matrix format: 4x4 unsigned 16-bit elements; element [r][c] at bits (r*4+c)*16 +: 16.
REQ-012 Ctrl layout: DataIn[2:0] opcode, DataIn[8] start; Ctrl reads return the stored opcode in bits [2:0], zeros elsewhere.
REQ-013 Opcodes: 0 ADD A+B, 1 SUB A-B, 2 EMUL elementwise A*B, 3 SCALE A*B[0][0], 4 TRANSPOSE result[r][c]=A[c][r]; 5-7 illegal.
REQ-014 Arithmetic modulo 2^16: sums, differences and products keep the low 16 bits; no saturation, no flags.
REQ-015 Hit write with nWrite low at edge: SrcA/SrcB/Ctrl updated from DataIn at that edge.
REQ-016 Hit read with nRead low and nWrite high at edge N: DataOut holds the selected register from edge N until the next edge; reserved offsets return 0.
REQ-017 DataOut is 0 after any edge without a hit read.
REQ-018 FSM states IDLE, COMPUTE, DONE; IDLE->COMPUTE on a Ctrl write with start=1 and a legal opcode.
REQ-019 COMPUTE processes one row per cycle: rows 0..3 on the 4 edges after acceptance into a working buffer; after row 3 -> DONE.
REQ-020 DONE: on the next edge Result <= working buffer, Status.done <= 1, state -> IDLE; Result updates exactly 5 edges after the accepting edge.
REQ-021 Busy = (state != IDLE), combinational from state.
REQ-022 Result holds the previous value throughout COMPUTE; no partial rows are visible.
REQ-023 Status: bit0 busy, bit1 done, bit2 error, other bits 0; a hit read of Status clears done and error after capture; a set on the same edge wins over the clear.
REQ-024 Error is set sticky by any of the following:
- start with an illegal opcode (no computation starts);
- any write while Busy (write ignored);
- a write to Result, Status or a reserved offset (write ignored);
- nRead and nWrite both low on a hit (the write executes; the read is ignored and DataOut is 0).
REQ-025 SrcA/SrcB are sampled row by row during COMPUTE; protection against change comes from REQ-024 alone.

Reset
REQ-026 Reset high asynchronously clears SrcA, SrcB, Ctrl, Result, the working buffer, Status and DataOut to 0, forces IDLE and drives Busy low.
REQ-027 Reset mid-COMPUTE aborts the operation; Result stays 0 and done is not set.
REQ-028 The first bus transaction is honoured at the first rising edge after Reset deasserts.

Structure
REQ-029 Package matrix_pkg holds the opcode enum, the register-offset constants, the FSM state enum and MAT_W=256 / ELEM_W=16.
REQ-030 Sub-module matrix_row_alu is combinational and computes one 64-bit result row from opcode, row index, SrcA, SrcB and B[0][0]; it is instantiated once.
REQ-031 All sequential logic uses one always_ff on posedge Clk or posedge Reset.

Verification
REQ-032 ADD: A all 0x0003, B all 0x0002, start -> Busy high 5 cycles, Result all 0x0005, Status=0x2 then 0x0 on the second read.
REQ-033 SUB wrap: A all 0x0001, B all 0x0002 -> Result all 0xFFFF; EMUL with A=B=0x0100 -> all 0x0000.
REQ-034 TRANSPOSE: A[r][c]=r*4+c -> Result[r][c]=c*4+r; SCALE with B[0][0]=3 on the same A -> 3*(r*4+c).
REQ-035 Error paths: opcode 6 with start -> Busy stays low, Status=0x4; SrcA write while Busy -> SrcA unchanged, error set.
REQ-036 Reset asserted on the 3rd COMPUTE cycle -> Busy low immediately, Result=0, Status=0; a new ADD afterwards completes normally.
REQ-037 Address outside the window (e.g. 16'h1000) with nRead low -> DataOut=0; nRead and nWrite both low on Ctrl -> Ctrl written, DataOut=0, error set.
